// File: rtl/loop_branch_controller_pkg.sv
// Shared types and default sizes for the BeeF loop/branch controller.
//   br_state_t : controller state as exposed on br_state_o
//   PC_T       : program counter word
//   BYTE       : tape cell value
package loop_branch_controller_pkg;

  localparam int unsigned BR_PC_W        = 16;
  localparam int unsigned BR_STACK_DEPTH = 16;
  localparam int unsigned BR_NEST_W      = 8;
  localparam int unsigned BYTE_W         = 8;

  typedef enum logic [1:0] {
    BR_IDLE  = 2'd0,
    BR_SKIP  = 2'd1,
    BR_JUMP  = 2'd2,
    BR_FAULT = 2'd3
  } br_state_t;

  typedef logic [BR_PC_W-1:0] PC_T;
  typedef logic [BYTE_W-1:0]  BYTE;

  // Loop condition: a zero cell skips/leaves the loop.
  function automatic logic byte_is_zero(input BYTE b);
    return (b == BYTE'(0));
  endfunction

endpackage

// File: rtl/loop_branch_controller_stack.sv
// LIFO of loop-open addresses.
//   push_i/pop_i : one entry per cycle; push when full / pop when empty are dropped
//   data_i       : address to push
//   top_o        : most recently pushed address (undefined when empty)
//   full_o       : occupancy == STACK_DEPTH
//   empty_o      : occupancy == 0
module loop_stack
  import loop_branch_controller_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = BR_STACK_DEPTH,
  parameter int unsigned PC_W        = BR_PC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] data_i,
  output logic [PC_W-1:0] top_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int unsigned AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  // One extra bit so occupancy can reach STACK_DEPTH itself.
  localparam int unsigned SPW = AW + 1;

  logic [SPW-1:0]  sp_q, sp_d;
  logic [PC_W-1:0] mem_q [STACK_DEPTH];
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   top_idx;

  assign full_o  = (sp_q == SPW'(STACK_DEPTH));
  assign empty_o = (sp_q == SPW'(0));
  assign wr_idx  = sp_q[AW-1:0];
  // At full occupancy wr_idx wraps to 0, so wr_idx-1 still names the last slot.
  assign top_idx = wr_idx - AW'(1);
  assign top_o   = mem_q[top_idx];

  // Occupancy update.
  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o) begin
      sp_d = sp_q + SPW'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - SPW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Storage carries no reset; entries are only read below the stack pointer.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/loop_branch_controller.sv
// PC redirection for BeeF '[' / ']' instructions.
//   instr_valid_i/op_open_i/op_close_i : decoded instruction from the decoder
//   prog_end_i  : fetch ran past the last program byte
//   pc_i        : address of the presented instruction
//   acc_i       : current cell value
//   pc_load_o   : one-cycle strobe, PC unit loads pc_target_o
//   pc_target_o : jump destination (loop-open address + 1)
//   core_stall_o: core must not execute the presented instruction
//   fault_o     : sticky error (overflow, underflow, unmatched '[', bad decode)
//   br_state_o  : current controller state
module loop_branch_controller
  import loop_branch_controller_pkg::*;
#(
  parameter int unsigned PC_W        = BR_PC_W,
  parameter int unsigned STACK_DEPTH = BR_STACK_DEPTH,
  parameter int unsigned NEST_W      = BR_NEST_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid_i,
  input  logic            op_open_i,
  input  logic            op_close_i,
  input  logic            prog_end_i,
  input  logic [PC_W-1:0] pc_i,
  input  BYTE             acc_i,
  output logic            pc_load_o,
  output logic [PC_W-1:0] pc_target_o,
  output logic            core_stall_o,
  output logic            fault_o,
  output br_state_t       br_state_o
);

  br_state_t         state_q, state_d;
  logic [NEST_W-1:0] nest_q, nest_d;
  logic [PC_W-1:0]   target_q, target_d;
  logic              pc_load_q, core_stall_q, fault_q;

  logic              acc_zero;
  logic              stk_push, stk_pop;
  logic [PC_W-1:0]   stk_top;
  logic              stk_full, stk_empty;

  assign acc_zero = byte_is_zero(acc_i);

  loop_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .PC_W        (PC_W)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (stk_push),
    .pop_i   (stk_pop),
    .data_i  (pc_i),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  // Next-state, nesting counter, jump target and stack controls.
  always_comb begin
    state_d  = state_q;
    nest_d   = nest_q;
    target_d = target_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;

    unique case (state_q)
      BR_IDLE: begin
        if (instr_valid_i) begin
          if (op_open_i && op_close_i) begin
            state_d = BR_FAULT;
          end else if (op_open_i) begin
            if (acc_zero) begin
              nest_d  = NEST_W'(1);
              state_d = BR_SKIP;
            end else if (stk_full) begin
              state_d = BR_FAULT;
            end else begin
              stk_push = 1'b1;
            end
          end else if (op_close_i) begin
            if (stk_empty) begin
              state_d = BR_FAULT;
            end else if (!acc_zero) begin
              // Loop again: jump just past the matching '[', which stays stacked.
              target_d = stk_top + PC_W'(1);
              state_d  = BR_JUMP;
            end else begin
              stk_pop = 1'b1;
            end
          end
        end
      end

      BR_SKIP: begin
        // Running off the end of the program beats whatever is presented.
        if (prog_end_i) begin
          state_d = BR_FAULT;
        end else if (instr_valid_i && op_open_i && !op_close_i) begin
          if (nest_q == {NEST_W{1'b1}}) begin
            state_d = BR_FAULT;
          end else begin
            nest_d = nest_q + NEST_W'(1);
          end
        end else if (instr_valid_i && op_close_i && !op_open_i) begin
          nest_d = nest_q - NEST_W'(1);
          if (nest_q == NEST_W'(1)) begin
            state_d = BR_IDLE;
          end
        end
      end

      BR_JUMP: begin
        state_d = BR_IDLE;
      end

      BR_FAULT: begin
        state_d = BR_FAULT;
      end

      default: begin
        state_d = BR_FAULT;
      end
    endcase
  end

  // State and registered outputs, all decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BR_IDLE;
      nest_q       <= '0;
      target_q     <= '0;
      pc_load_q    <= 1'b0;
      core_stall_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      nest_q       <= nest_d;
      target_q     <= target_d;
      pc_load_q    <= (state_d == BR_JUMP);
      core_stall_q <= (state_d != BR_IDLE);
      fault_q      <= (state_d == BR_FAULT);
    end
  end

  assign pc_load_o    = pc_load_q;
  assign pc_target_o  = target_q;
  assign core_stall_o = core_stall_q;
  assign fault_o      = fault_q;
  assign br_state_o   = state_q;

endmodule
